snake_body_buffer: RTL

SNAKE_BODY_BUFFER -- requirements
Module: snake_body_buffer

---
 rtl/snake_pkg.sv | 15 +
 rtl/snake_seg_ram.sv | 52 +++++
 rtl/snake_body_buffer.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/snake_pkg.sv
// Shared definitions for the snake body storage: scan FSM encoding and
// default coordinate widths / grid pitch.
package snake_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int unsigned XW_DEF   = 8;
    localparam int unsigned YW_DEF   = 7;
    localparam int unsigned CELL_DEF = 10;

endpackage

// File: rtl/snake_seg_ram.sv
// Segment store: DEPTH x (XW+YW) words, one write port, two combinational
// read ports; reset loads the initial vertical body starting at (X0, Y0).
module snake_seg_ram
    import snake_pkg::*;
#(
    parameter int unsigned XW       = XW_DEF,
    parameter int unsigned YW       = YW_DEF,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned INIT_LEN = 4,
    parameter int unsigned X0       = 80,
    parameter int unsigned Y0       = 60,
    parameter int unsigned CELL     = CELL_DEF
)(
    input  logic                     CLOCK_50,
    input  logic                     Resetn,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [XW+YW-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr_a,
    output logic [XW+YW-1:0]         rdata_a,
    input  logic [$clog2(DEPTH)-1:0] raddr_b,
    output logic [XW+YW-1:0]         rdata_b
);

    logic [XW+YW-1:0] mem_q [DEPTH];
    logic [XW+YW-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (i < INIT_LEN) begin
                    mem_q[i] <= {XW'(X0), YW'(Y0 + i * CELL)};
                end else begin
                    mem_q[i] <= '0;
                end
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata_a = mem_q[raddr_a];
    assign rdata_b = mem_q[raddr_b];

endmodule

// File: rtl/snake_body_buffer.sv
// Snake body as a circular buffer of segments (head at hp) with a serial
// head-vs-body collision scan after every accepted move.
module snake_body_buffer
    import snake_pkg::*;
#(
    parameter int unsigned XW       = XW_DEF,
    parameter int unsigned YW       = YW_DEF,
    parameter int unsigned MAXLEN   = 16,
    parameter int unsigned INIT_LEN = 4,
    parameter int unsigned X0       = 80,
    parameter int unsigned Y0       = 60,
    parameter int unsigned CELL     = CELL_DEF
)(
    input  logic                      CLOCK_50,
    input  logic                      Resetn,
    input  logic                      step_valid,
    output logic                      step_ready,
    input  logic                      step_grow,
    input  logic [XW-1:0]             new_x,
    input  logic [YW-1:0]             new_y,
    input  logic [$clog2(MAXLEN)-1:0] rd_idx,
    output logic [XW-1:0]             rd_x,
    output logic [YW-1:0]             rd_y,
    output logic                      rd_ok,
    output logic [$clog2(MAXLEN):0]   length,
    output logic                      full,
    output logic                      hit_valid,
    output logic                      hit,
    output logic                      grow_drop
);

    localparam int unsigned AW = $clog2(MAXLEN);
    localparam int unsigned LW = AW + 1;

    state_t         state_q, state_d;
    logic [AW-1:0]  hp_q, hp_d;
    logic [LW-1:0]  len_q, len_d;
    logic [AW-1:0]  k_q, k_d;
    logic           match_q, match_d;
    logic           hit_q, hit_d;
    logic           hit_valid_q, hit_valid_d;
    logic           grow_drop_q, grow_drop_d;
    logic [XW-1:0]  head_x_q, head_x_d;
    logic [YW-1:0]  head_y_q, head_y_d;
    logic [XW-1:0]  rd_x_q, rd_x_d;
    logic [YW-1:0]  rd_y_q, rd_y_d;
    logic           rd_ok_q, rd_ok_d;

    logic              we;
    logic [AW-1:0]     waddr;
    logic [AW-1:0]     raddr_a, raddr_b;
    logic [XW+YW-1:0]  rdata_a, rdata_b;
    logic              full_w;

    snake_seg_ram #(
        .XW       (XW),
        .YW       (YW),
        .DEPTH    (MAXLEN),
        .INIT_LEN (INIT_LEN),
        .X0       (X0),
        .Y0       (Y0),
        .CELL     (CELL)
    ) u_ram (
        .CLOCK_50 (CLOCK_50),
        .Resetn   (Resetn),
        .we       (we),
        .waddr    (waddr),
        .wdata    ({new_x, new_y}),
        .raddr_a  (raddr_a),
        .rdata_a  (rdata_a),
        .raddr_b  (raddr_b),
        .rdata_b  (rdata_b)
    );

    assign full_w  = (len_q == LW'(MAXLEN));
    assign waddr   = hp_q - AW'(1);
    assign raddr_a = hp_q + rd_idx;
    assign raddr_b = hp_q + k_q;

    always_comb begin
        state_d     = state_q;
        hp_d        = hp_q;
        len_d       = len_q;
        k_d         = k_q;
        match_d     = match_q;
        hit_d       = hit_q;
        hit_valid_d = 1'b0;
        grow_drop_d = 1'b0;
        head_x_d    = head_x_q;
        head_y_d    = head_y_q;
        we          = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (step_valid) begin
                    we       = 1'b1;
                    hp_d     = hp_q - AW'(1);
                    head_x_d = new_x;
                    head_y_d = new_y;
                    if (step_grow) begin
                        if (full_w) begin
                            grow_drop_d = 1'b1;
                        end else begin
                            len_d = len_q + LW'(1);
                        end
                    end
                    k_d     = AW'(1);
                    match_d = 1'b0;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                // Head is held in head_*_q so port B is free for segment k;
                // the k < length guard makes a length-1 scan compare nothing.
                if ((LW'(k_q) < len_q) &&
                    (rdata_b == {head_x_q, head_y_q})) begin
                    match_d = 1'b1;
                end
                if ((LW'(k_q) + LW'(1)) >= len_q) begin
                    state_d = ST_DONE;
                end else begin
                    k_d = k_q + AW'(1);
                end
            end
            ST_DONE: begin
                hit_valid_d = 1'b1;
                hit_d       = match_q;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        rd_ok_d = (LW'(rd_idx) < len_q);
        rd_x_d  = rd_ok_d ? rdata_a[XW+YW-1:YW] : '0;
        rd_y_d  = rd_ok_d ? rdata_a[YW-1:0]     : '0;
    end

    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            state_q     <= ST_IDLE;
            hp_q        <= '0;
            len_q       <= LW'(INIT_LEN);
            k_q         <= '0;
            match_q     <= 1'b0;
            hit_q       <= 1'b0;
            hit_valid_q <= 1'b0;
            grow_drop_q <= 1'b0;
            head_x_q    <= '0;
            head_y_q    <= '0;
            rd_x_q      <= '0;
            rd_y_q      <= '0;
            rd_ok_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            hp_q        <= hp_d;
            len_q       <= len_d;
            k_q         <= k_d;
            match_q     <= match_d;
            hit_q       <= hit_d;
            hit_valid_q <= hit_valid_d;
            grow_drop_q <= grow_drop_d;
            head_x_q    <= head_x_d;
            head_y_q    <= head_y_d;
            rd_x_q      <= rd_x_d;
            rd_y_q      <= rd_y_d;
            rd_ok_q     <= rd_ok_d;
        end
    end

    assign step_ready = (state_q == ST_IDLE);
    assign length     = len_q;
    assign full       = full_w;
    assign hit_valid  = hit_valid_q;
    assign hit        = hit_q;
    assign grow_drop  = grow_drop_q;
    assign rd_x       = rd_x_q;
    assign rd_y       = rd_y_q;
    assign rd_ok      = rd_ok_q;

endmodule
